// File: rtl/l2_sumsq_acc.sv
// l2_sumsq_acc: streaming sum-of-squares over fixed-length vectors of signed
// samples. Three register stages: E0 captures the sample and its index, E1
// squares it, E2 accumulates and publishes one result per VEC_LEN samples.
module l2_sumsq_acc #(
   parameter int IN_W    = 8,
   parameter int OUT_W   = 10,
   parameter int VEC_LEN = 4,
   parameter int SAT     = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic signed [IN_W-1:0] a,
   input  logic                   valid_in,
   output logic [OUT_W-1:0]       g,
   output logic                   valid_out,
   output logic                   overflow
);

   localparam int CNT_W = $clog2(VEC_LEN);
   localparam int SQ_W  = 2 * IN_W;
   // Wide enough to hold a wrapped partial sum plus any square without loss.
   localparam int SUM_W = ((SQ_W > OUT_W) ? SQ_W : OUT_W) + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);
   localparam logic [OUT_W-1:0] G_MAX    = {OUT_W{1'b1}};

   // Square of a two's-complement sample; sign-extending first keeps the
   // most negative value exact.
   function automatic logic [SQ_W-1:0] square(input logic signed [IN_W-1:0] x);
      logic signed [SQ_W-1:0] xe;
      xe = $signed({{IN_W{x[IN_W-1]}}, x});
      return $unsigned(xe * xe);
   endfunction

   // E0 stage
   logic [CNT_W-1:0]       cnt_r;
   logic signed [IN_W-1:0] a0_r;
   logic [CNT_W-1:0]       idx0_r;
   logic                   v0_r;
   // E1 stage
   logic [SQ_W-1:0]        sq1_r;
   logic [CNT_W-1:0]       idx1_r;
   logic                   v1_r;
   // E2 stage: the wrapped sum is kept modulo 2^OUT_W; the sticky bit
   // remembers whether the true sum ever left that range.
   logic [OUT_W-1:0]       acc_r;
   logic                   sticky_r;

   logic [SUM_W-1:0]       base_s;
   logic [SUM_W-1:0]       sum_s;
   logic                   part_ovf_s;
   logic                   total_ovf_s;
   logic [OUT_W-1:0]       g_next_s;

   // Next accumulator value, overflow status and result for the sample at E2.
   always_comb begin
      base_s      = {SUM_W{1'b0}};
      sum_s       = {SUM_W{1'b0}};
      part_ovf_s  = 1'b0;
      total_ovf_s = 1'b0;
      g_next_s    = {OUT_W{1'b0}};
      if (idx1_r == {CNT_W{1'b0}}) begin
         base_s = {SUM_W{1'b0}};
      end else begin
         base_s = SUM_W'(acc_r);
      end
      sum_s      = base_s + SUM_W'(sq1_r);
      part_ovf_s = |sum_s[SUM_W-1:OUT_W];
      if (idx1_r == {CNT_W{1'b0}}) begin
         total_ovf_s = part_ovf_s;
      end else begin
         total_ovf_s = sticky_r | part_ovf_s;
      end
      if ((SAT != 0) && total_ovf_s) begin
         g_next_s = G_MAX;
      end else begin
         g_next_s = sum_s[OUT_W-1:0];
      end
   end

   // E0: accept a sample, tag it with its position in the vector.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r  <= {CNT_W{1'b0}};
         a0_r   <= {IN_W{1'b0}};
         idx0_r <= {CNT_W{1'b0}};
         v0_r   <= 1'b0;
      end else if (clear) begin
         cnt_r <= {CNT_W{1'b0}};
         v0_r  <= 1'b0;
      end else begin
         v0_r <= valid_in;
         if (valid_in) begin
            a0_r   <= a;
            idx0_r <= cnt_r;
            if (cnt_r == LAST_IDX) begin
               cnt_r <= {CNT_W{1'b0}};
            end else begin
               cnt_r <= cnt_r + CNT_W'(1);
            end
         end
      end
   end

   // E1: register the square and carry the index along.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sq1_r  <= {SQ_W{1'b0}};
         idx1_r <= {CNT_W{1'b0}};
         v1_r   <= 1'b0;
      end else if (clear) begin
         v1_r <= 1'b0;
      end else begin
         v1_r <= v0_r;
         if (v0_r) begin
            sq1_r  <= square(a0_r);
            idx1_r <= idx0_r;
         end
      end
   end

   // E2: accumulate and publish the result when the last index arrives.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_r     <= {OUT_W{1'b0}};
         sticky_r  <= 1'b0;
         g         <= {OUT_W{1'b0}};
         valid_out <= 1'b0;
         overflow  <= 1'b0;
      end else if (clear) begin
         acc_r     <= {OUT_W{1'b0}};
         sticky_r  <= 1'b0;
         valid_out <= 1'b0;
         overflow  <= 1'b0;
      end else if (v1_r) begin
         acc_r    <= sum_s[OUT_W-1:0];
         sticky_r <= total_ovf_s;
         if (idx1_r == LAST_IDX) begin
            g         <= g_next_s;
            overflow  <= total_ovf_s;
            valid_out <= 1'b1;
         end else begin
            overflow  <= 1'b0;
            valid_out <= 1'b0;
         end
      end else begin
         overflow  <= 1'b0;
         valid_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_l2_sumsq_acc.sv
// Bench for l2_sumsq_acc: directed scenarios plus random streams, checked
// every cycle against a vector-level model (sample list, integer sums,
// pending-result latency list). Two instances cover wrap and saturate modes.
module tb_l2_sumsq_acc;

   localparam int VEC_LEN = 4;
   localparam int G_MOD   = 1024;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              clear = 1'b0;
   logic signed [7:0] a = 8'sd0;
   logic              valid_in = 1'b0;
   logic [9:0]        g0, g1;
   logic              v0, v1, o0, o1;

   int n_chk = 0;
   int n_err = 0;
   int pulses = 0;

   typedef struct { int rem; int sum; } pend_t;
   pend_t pend_q[$];
   int    samp_q[$];
   int    exp_g = 0, exp_gs = 0, exp_v = 0, exp_o = 0;

   always #5 clk = ~clk;

   l2_sumsq_acc #(.IN_W(8), .OUT_W(10), .VEC_LEN(VEC_LEN), .SAT(0)) dut0 (
      .clk(clk), .reset(reset), .clear(clear), .a(a), .valid_in(valid_in),
      .g(g0), .valid_out(v0), .overflow(o0));

   l2_sumsq_acc #(.IN_W(8), .OUT_W(10), .VEC_LEN(VEC_LEN), .SAT(1)) dut1 (
      .clk(clk), .reset(reset), .clear(clear), .a(a), .valid_in(valid_in),
      .g(g1), .valid_out(v1), .overflow(o1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_zero();
      samp_q.delete();
      pend_q.delete();
      exp_g = 0; exp_gs = 0; exp_v = 0; exp_o = 0;
   endtask

   // Model reaction to one rising edge with the given inputs.
   task automatic model_edge(input logic vin, input int av, input logic clr);
      int s;
      if (reset == 1'b0) begin
         model_zero();
      end else if (clr) begin
         samp_q.delete();
         pend_q.delete();
         exp_v = 0; exp_o = 0;
      end else begin
         exp_v = 0; exp_o = 0;
         foreach (pend_q[i]) pend_q[i].rem--;
         if (pend_q.size() > 0 && pend_q[0].rem == 0) begin
            s      = pend_q[0].sum;
            exp_v  = 1;
            exp_o  = (s > G_MOD - 1) ? 1 : 0;
            exp_g  = s % G_MOD;
            exp_gs = exp_o ? G_MOD - 1 : s % G_MOD;
            void'(pend_q.pop_front());
         end
         if (vin) begin
            samp_q.push_back(av);
            if (samp_q.size() == VEC_LEN) begin
               s = 0;
               foreach (samp_q[i]) s += samp_q[i] * samp_q[i];
               pend_q.push_back('{rem: 2, sum: s});
               samp_q.delete();
            end
         end
      end
   endtask

   task automatic check_outputs();
      chk("g", 32'(g0), 32'(exp_g));
      chk("valid_out", 32'(v0), 32'(exp_v));
      chk("overflow", 32'(o0), 32'(exp_o));
      chk("g_sat", 32'(g1), 32'(exp_gs));
      chk("valid_out_sat", 32'(v1), 32'(exp_v));
      chk("overflow_sat", 32'(o1), 32'(exp_o));
   endtask

   task automatic step(input logic vin, input int av, input logic clr);
      logic [31:0] aw;
      aw       = 32'(av);
      valid_in = vin;
      a        = aw[7:0];
      clear    = clr;
      @(posedge clk);
      model_edge(vin, av, clr);
      #1;
      if (v0) pulses++;
      check_outputs();
   endtask

   task automatic assert_reset();
      #2;
      reset = 1'b0;
      #1;
      model_zero();
      check_outputs();
   endtask

   initial begin
      // Reset held across edges, with samples offered that must be ignored.
      step(1'b1, 7, 1'b0);
      step(1'b1, 7, 1'b0);
      reset = 1'b1;

      // No valid input at all: no result, g stays 0.
      for (int i = 0; i < 20; i++) step(1'b0, i % 128, 1'b0);
      chk("idle_g", 32'(g0), 32'd0);

      // Back-to-back 3,4,-5,0 -> 50 three edges after the last sample.
      step(1'b1, 3, 1'b0); step(1'b1, 4, 1'b0); step(1'b1, -5, 1'b0); step(1'b1, 0, 1'b0);
      step(1'b0, 9, 1'b0);
      chk("b2b_early_valid", 32'(v0), 32'd0);
      step(1'b0, 9, 1'b0);
      chk("b2b_valid", 32'(v0), 32'd1);
      chk("b2b_g", 32'(g0), 32'd50);
      step(1'b0, 9, 1'b0);

      // Same vector with gaps and a toggling while idle.
      pulses = 0;
      begin
         int smp[4] = '{3, 4, -5, 0};
         for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < int'($urandom_range(0, 3)); k++)
               step(1'b0, int'($urandom_range(0, 255)) - 128, 1'b0);
            step(1'b1, smp[i], 1'b0);
         end
      end
      for (int i = 0; i < 5; i++) step(1'b0, i, 1'b0);
      chk("gaps_g", 32'(g0), 32'd50);
      chk("gaps_pulses", 32'(pulses), 32'd1);

      // Overflow: 127 x4, then 1 x4.
      for (int i = 0; i < 4; i++) step(1'b1, 127, 1'b0);
      step(1'b0, 0, 1'b0); step(1'b0, 0, 1'b0);
      chk("ovf_g_wrap", 32'(g0), 32'd4);
      chk("ovf_g_sat", 32'(g1), 32'd1023);
      chk("ovf_flag", 32'(o0), 32'd1);
      for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0);
      step(1'b0, 0, 1'b0); step(1'b0, 0, 1'b0);
      chk("post_ovf_g", 32'(g1), 32'd4);
      chk("post_ovf_flag", 32'(o1), 32'd0);

      // Most negative input.
      step(1'b1, -128, 1'b0); step(1'b1, 0, 1'b0); step(1'b1, 0, 1'b0); step(1'b1, 1, 1'b0);
      step(1'b0, 0, 1'b0); step(1'b0, 0, 1'b0);
      chk("minneg_g", 32'(g0), 32'((16384 + 1) % 1024));

      // Reset mid-vector discards the partial sum.
      step(1'b1, 10, 1'b0); step(1'b1, 10, 1'b0);
      assert_reset();
      step(1'b1, 10, 1'b0);
      reset = 1'b1;
      step(1'b1, 1, 1'b0); step(1'b1, 2, 1'b0); step(1'b1, 2, 1'b0); step(1'b1, 0, 1'b0);
      step(1'b0, 0, 1'b0); step(1'b0, 0, 1'b0);
      chk("reset_g", 32'(g0), 32'd9);

      // Clear with a simultaneous sample drops it.
      step(1'b1, 5, 1'b0); step(1'b1, 5, 1'b0); step(1'b1, 5, 1'b1);
      chk("clear_hold_g", 32'(g0), 32'd9);
      for (int i = 0; i < 4; i++) step(1'b1, 2, 1'b0);
      step(1'b0, 0, 1'b0); step(1'b0, 0, 1'b0);
      chk("clear_g", 32'(g0), 32'd16);

      // Random streams: gaps, occasional clear, mixed magnitudes.
      for (int i = 0; i < 600; i++) begin
         int av;
         if (i < 300) av = int'($urandom_range(0, 255)) - 128;
         else         av = int'($urandom_range(0, 20)) - 10;
         step(($urandom % 3) != 0, av, ($urandom % 40) == 0);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/l2_sumsq_acc.md
L2_SUMSQ_ACC -- requirements
Module: l2_sumsq_acc

Interface
REQ-001 SHALL have parameter IN_W, default 8, meaning signed input sample width (two's complement).
REQ-002 SHALL have parameter OUT_W, default 10, meaning unsigned result width of g.
REQ-003 SHALL have parameter VEC_LEN, default 4, meaning number of valid samples per sum-of-squares result (legal range 2..256).
REQ-004 SHALL have parameter SAT, default 0, meaning overflow mode (0 = wrap modulo 2^OUT_W, 1 = saturate to 2^OUT_W-1).
REQ-005 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-007 SHALL have port clear  input  1  synchronous abort of the current vector.
REQ-008 SHALL have port a  input  IN_W  signed sample.
REQ-009 SHALL have port valid_in  input  1  a is valid this cycle.
REQ-010 SHALL have port g  output  OUT_W  sum of squares of the last completed vector.
REQ-011 SHALL have port valid_out  output  1  one-cycle pulse, g holds a new result.
REQ-012 SHALL have port overflow  output  1  the result with this valid_out exceeded 2^OUT_W-1.

Function
REQ-013 SHALL accept a sample on every rising edge where valid_in=1 and clear=0; when valid_in=0, a SHALL be ignored and internal state SHALL NOT change.
REQ-014 SHALL pipeline in three register stages: E0 input register, E1 square register (2*IN_W bits, unsigned), E2 accumulate/output.
REQ-015 SHALL count accepted samples with a counter 0..VEC_LEN-1, wrapping to 0 after VEC_LEN-1; the counter value travels with each sample through the pipe.
REQ-016 SHALL assign the accumulator at E2 for a sample tagged index 0 (square loaded, not added), and add the square for all other indices.
REQ-017 SHALL hold the accumulator at OUT_W+1 bits plus a sticky overflow bit set when any partial sum exceeds 2^OUT_W-1; the sticky bit clears at the index-0 load.
REQ-018 SHALL, at E2 of the sample tagged VEC_LEN-1, register g, overflow and valid_out=1; valid_out SHALL fall the next cycle unless another vector completes.
REQ-019 SHALL set latency to exactly 3 rising edges: sample accepted at edge E gives valid_out high in the cycle following edge E+2.
REQ-020 SHALL allow arbitrary gaps in valid_in; results SHALL equal those for back-to-back samples.
REQ-021 SHALL sustain one sample per cycle; vectors may abut with no idle cycle, with one valid_out per VEC_LEN samples.
REQ-022 SHALL, when SAT=0, drive g = true sum mod 2^OUT_W; when SAT=1, drive g = 2^OUT_W-1 whenever overflow=1.
REQ-023 SHALL hold g between valid_out pulses; overflow SHALL be 0 whenever valid_out=0.
REQ-024 SHALL, on clear=1, zero the counter, accumulator, sticky bit and all in-flight pipeline valids at that edge; a valid_in at the same edge SHALL be dropped; g SHALL keep its last value.
REQ-025 SHALL compute the square of the most negative input correctly (e.g. -128 gives 16384 for IN_W=8).

Reset
REQ-026 SHALL, while reset=0, asynchronously force g=0, valid_out=0, overflow=0, counter=0, accumulator=0 and all pipeline valids to 0.
REQ-027 SHALL discard a partially accumulated vector on reset assertion; the first sample accepted after reset release SHALL be index 0.
REQ-028 SHALL NOT accept samples on the edge where reset is still 0.

Verification (defaults unless stated)
REQ-029 SHALL pass: a=3,4,-5,0 with valid_in=1 back-to-back -> 3 edges after the last sample, one-cycle valid_out, g=50, overflow=0.
REQ-030 SHALL pass: the same four samples with 0-3 idle cycles between each, and a toggling while valid_in=0 -> g=50, exactly one valid_out.
REQ-031 SHALL pass: a toggling 0..127 for 20 cycles with valid_in=0 throughout -> valid_out never asserts, g stays 0.
REQ-032 SHALL pass: a=127 x4 -> overflow=1 with g=4 for SAT=0; g=1023 for SAT=1; the next vector 1,1,1,1 -> g=4, overflow=0.
REQ-033 SHALL pass: samples 10,10, then reset low mid-vector, then 1,2,2,0 -> all outputs 0 during reset, then g=9.
REQ-034 SHALL pass: samples 5,5, then clear=1 with valid_in=1, a=5, then 2,2,2,2 -> g=16; the cleared-edge sample is not counted.
